// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator for signed or unsigned operands.
// One bit per clock, with optional early exit at the first differing bit.
module serial_mag_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    input  logic                       signed_mode,
    output logic                       busy,
    output logic                       done,
    output logic                       lt,
    output logic                       eq,
    output logic                       gt,
    output logic [$clog2(WIDTH+1)-1:0] nbits
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH+1);
    localparam logic [IW-1:0] TOP = IW'(WIDTH-1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] ya;
    logic             sm;
    logic [IW-1:0]    idx;
    logic             found;
    logic             found_lt;

    logic bx;
    logic by;
    logic diff;
    logic x_less;
    logic dec_found;
    logic dec_lt;
    logic finish;

    // The sign bit inverts the ordering: a 1 there marks the smaller value.
    always_comb begin
        bx        = xa[idx];
        by        = ya[idx];
        diff      = bx ^ by;
        x_less    = (sm && idx == TOP) ? bx : by;
        dec_found = found | diff;
        dec_lt    = found ? found_lt : x_less;
        finish    = (idx == '0) || (EARLY_EXIT && diff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (finish) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xa       <= '0;
            ya       <= '0;
            sm       <= 1'b0;
            idx      <= '0;
            found    <= 1'b0;
            found_lt <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            nbits    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xa       <= x;
                        ya       <= y;
                        sm       <= signed_mode;
                        idx      <= TOP;
                        found    <= 1'b0;
                        found_lt <= 1'b0;
                        lt       <= 1'b0;
                        eq       <= 1'b0;
                        gt       <= 1'b0;
                        nbits    <= '0;
                    end
                end
                ST_SHIFT: begin
                    nbits <= nbits + CW'(1);
                    if (!found && diff) begin
                        found    <= 1'b1;
                        found_lt <= x_less;
                    end
                    if (finish) begin
                        lt <= dec_found & dec_lt;
                        gt <= dec_found & ~dec_lt;
                        eq <= ~dec_found;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: directed 8-bit vectors on
// early-exit and full-scan instances, plus an exhaustive 2-bit sweep.
module tb_serial_mag_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] x8, y8;
    logic       sm8;
    logic       start_a, start_b;
    logic       busy_a, done_a, lt_a, eq_a, gt_a;
    logic       busy_b, done_b, lt_b, eq_b, gt_b;
    logic [3:0] nb_a, nb_b;
    logic [1:0] x2, y2;
    logic       sm2, start_c;
    logic       busy_c, done_c, lt_c, eq_c, gt_c;
    logic [1:0] nb_c;

    typedef struct packed {
        logic       lt;
        logic       eq;
        logic       gt;
        logic [3:0] nb;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   total = 0;
    int   bad = 0;
    int   dones_c = 0;

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .x(x8), .y(y8),
        .signed_mode(sm8), .busy(busy_a), .done(done_a),
        .lt(lt_a), .eq(eq_a), .gt(gt_a), .nbits(nb_a)
    );

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .x(x8), .y(y8),
        .signed_mode(sm8), .busy(busy_b), .done(done_b),
        .lt(lt_b), .eq(eq_b), .gt(gt_b), .nbits(nb_b)
    );

    serial_mag_comparator #(.WIDTH(2), .EARLY_EXIT(1'b1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .x(x2), .y(y2),
        .signed_mode(sm2), .busy(busy_c), .done(done_c),
        .lt(lt_c), .eq(eq_c), .gt(gt_c), .nbits(nb_c)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic spurious(input string name);
        total++;
        bad++;
        $display("FAIL %s done with empty scoreboard", name);
    endtask

    // An aborted compare never reports, so its expectation is dropped.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            qc.delete();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (qa.size() == 0) spurious("a_done");
            else begin
                e = qa.pop_front();
                chk("a_flags", {lt_a, eq_a, gt_a}, {e.lt, e.eq, e.gt});
                chk("a_nbits", nb_a, e.nb);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_b) begin
            if (qb.size() == 0) spurious("b_done");
            else begin
                e = qb.pop_front();
                chk("b_flags", {lt_b, eq_b, gt_b}, {e.lt, e.eq, e.gt});
                chk("b_nbits", nb_b, e.nb);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_c) begin
            dones_c++;
            if (qc.size() == 0) spurious("c_done");
            else begin
                e = qc.pop_front();
                chk("c_flags", {lt_c, eq_c, gt_c}, {e.lt, e.eq, e.gt});
                chk("c_nbits", nb_c, e.nb);
            end
        end
    end

    task automatic wait_idle(input string name, input logic which);
        int k = 0;
        while ((which ? busy_b : busy_a) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (which ? busy_b : busy_a) begin
            total++;
            bad++;
            $display("FAIL %s timeout busy still high", name);
        end
    endtask

    task automatic run(input logic which, input logic [7:0] a,
                       input logic [7:0] b, input logic s,
                       input logic l, input logic e, input logic g,
                       input logic [3:0] n);
        exp_t ex;
        ex = '{lt: l, eq: e, gt: g, nb: n};
        @(negedge clk);
        if (which) qb.push_back(ex);
        else qa.push_back(ex);
        x8 = a;
        y8 = b;
        sm8 = s;
        if (which) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        wait_idle("run", which);
    endtask

    initial begin
        logic seen;
        int   k;
        rst = 1'b1;
        start_a = 0; start_b = 0; start_c = 0;
        x8 = 0; y8 = 0; sm8 = 0; x2 = 0; y2 = 0; sm2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_a", {busy_a, done_a, lt_a, eq_a, gt_a, nb_a}, 0);
        chk("rst_b", {busy_b, done_b, lt_b, eq_b, gt_b, nb_b}, 0);
        chk("rst_c", {busy_c, done_c, lt_c, eq_c, gt_c, nb_c}, 0);
        rst = 1'b0;

        // Equal operands: full scan with exact done latency.
        @(negedge clk);
        qa.push_back('{lt: 0, eq: 1, gt: 0, nb: 4'd8});
        x8 = 8'h35; y8 = 8'h35; sm8 = 0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        x8 = 8'h00;
        chk("t1_busy", busy_a, 1);
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            seen |= done_a;
        end
        chk("t1_early_done", seen, 0);
        @(negedge clk);
        chk("t1_done", {busy_a, done_a}, 2'b11);
        @(negedge clk);
        chk("t1_after", {busy_a, done_a}, 2'b00);
        chk("t1_hold", {lt_a, eq_a, gt_a, nb_a}, {3'b010, 4'd8});

        run(0, 8'h80, 8'h7F, 0, 0, 0, 1, 4'd1);
        run(0, 8'h80, 8'h7F, 1, 1, 0, 0, 4'd1);
        run(0, 8'h12, 8'h13, 0, 1, 0, 0, 4'd8);
        run(0, 8'hFE, 8'h01, 1, 1, 0, 0, 4'd1);
        run(0, 8'hFE, 8'hFD, 1, 0, 0, 1, 4'd7);
        run(1, 8'hF0, 8'h0F, 0, 0, 0, 1, 4'd8);
        run(1, 8'h81, 8'h7F, 1, 1, 0, 0, 4'd8);
        run(1, 8'hA5, 8'hA5, 1, 0, 1, 0, 4'd8);

        // A start while busy must neither restart nor re-sample.
        @(negedge clk);
        qa.push_back('{lt: 1, eq: 0, gt: 0, nb: 4'd3});
        x8 = 8'h10; y8 = 8'h20; sm8 = 0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        x8 = 8'hFF; y8 = 8'h00; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle("t4", 0);
        repeat (3) @(negedge clk);
        chk("t4_no_restart", busy_a, 0);

        // Reset mid-compare discards the in-flight result.
        x8 = 8'h55; y8 = 8'h55; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst", {busy_a, done_a, lt_a, eq_a, gt_a, nb_a}, 0);
        run(0, 8'h01, 8'h00, 0, 0, 0, 1, 4'd8);

        // 2-bit exhaustive sweep with start held high.
        @(negedge clk);
        start_c = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                logic [1:0] a, b;
                logic       l, g;
                exp_t       ex;
                a = i[3:2];
                b = i[1:0];
                if (s == 1) begin
                    l = $signed(a) < $signed(b);
                    g = $signed(a) > $signed(b);
                end else begin
                    l = a < b;
                    g = a > b;
                end
                ex = '{lt: l, eq: (a == b), gt: g,
                       nb: (a[1] != b[1]) ? 4'd1 : 4'd2};
                qc.push_back(ex);
                x2 = a;
                y2 = b;
                sm2 = s[0];
                @(negedge clk);
                k = 0;
                while (!done_c && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                if (!done_c) begin
                    total++;
                    bad++;
                    $display("FAIL t6_timeout pair=%0d mode=%0d", i, s);
                end
            end
        end
        start_c = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_dones", dones_c, 32);
        chk("t6_idle", busy_c, 0);
        chk("qa_left", qa.size(), 0);
        chk("qb_left", qb.size(), 0);
        chk("qc_left", qc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
